// File: rtl/iob_jbi_rptr_pkg.sv
// ============================================================================
// Module  : iob_jbi_rptr_pkg
// Brief   : Shared widths, credit depth and FSM encoding for the IOB->JBI
//           repeater arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package iob_jbi_rptr_pkg;

    localparam int DW      = 136;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/iob_jbi_rptr_credit.sv
// ============================================================================
// Module  : iob_jbi_rptr_credit
// Brief   : JBI beat-credit counter with availability flag and sticky
//           over-return error.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_jbi_rptr_credit
    import iob_jbi_rptr_pkg::*;
(
    input  logic          clk,
    input  logic          rst_l,
    input  logic          consume,
    input  logic          credit_ret,
    output logic [CW-1:0] credit_cnt,
    output logic          credit_avail,
    output logic          credit_ovf
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        case ({consume, credit_ret})
            2'b10: cnt_d = cnt_q - CW'(1);
            2'b01: begin
                // A return with the buffer already fully credited is dropped.
                if (cnt_q == CW'(CREDITS)) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_q <= CW'(CREDITS);
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign credit_cnt   = cnt_q;
    assign credit_avail = (cnt_q != '0);
    assign credit_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/iob_jbi_rptr_arb.sv
// ============================================================================
// Module  : iob_jbi_rptr_arb
// Brief   : Packet-granular round-robin arbiter between two IOB sources onto
//           the credited, registered IOB->JBI repeater path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_jbi_rptr_arb
    import iob_jbi_rptr_pkg::*;
(
    input  logic          clk,
    input  logic          rst_l,
    input  logic          req0_vld,
    input  logic          req0_last,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ack,
    input  logic          req1_vld,
    input  logic          req1_last,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ack,
    input  logic          jbi_credit_ret,
    output logic          sig_buf_vld,
    output logic [DW-1:0] sig_buf,
    output logic [CW-1:0] credit_cnt,
    output logic          credit_ovf
);

    state_e        state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          gnt0, gnt1;
    logic          ack0, ack1;
    logic          credit_avail;
    logic          sig_buf_vld_q, sig_buf_vld_d;
    logic [DW-1:0] sig_buf_q, sig_buf_d;

    iob_jbi_rptr_credit u_credit (
        .clk          (clk),
        .rst_l        (rst_l),
        .consume      (ack0 | ack1),
        .credit_ret   (jbi_credit_ret),
        .credit_cnt   (credit_cnt),
        .credit_avail (credit_avail),
        .credit_ovf   (credit_ovf)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (ack0) begin
                    if (req0_last) rr_ptr_d = 1'b1;
                    else           state_d  = LOCK0;
                end else if (ack1) begin
                    if (req1_last) rr_ptr_d = 1'b0;
                    else           state_d  = LOCK1;
                end
            end
            LOCK0: begin
                if (ack0 && req0_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = 1'b1;
                end
            end
            LOCK1: begin
                if (ack1 && req1_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Acks are forced low while reset is held so nothing is consumed.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_vld && req1_vld) begin
                    gnt0 = ~rr_ptr_q;
                    gnt1 = rr_ptr_q;
                end else begin
                    gnt0 = req0_vld;
                    gnt1 = req1_vld;
                end
            end
            LOCK0:   gnt0 = 1'b1;
            LOCK1:   gnt1 = 1'b1;
            default: ;
        endcase
        ack0 = rst_l & credit_avail & gnt0 & req0_vld;
        ack1 = rst_l & credit_avail & gnt1 & req1_vld;
    end

    always_comb begin
        sig_buf_vld_d = ack0 | ack1;
        sig_buf_d     = sig_buf_q;
        if (ack0)      sig_buf_d = req0_data;
        else if (ack1) sig_buf_d = req1_data;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sig_buf_vld_q <= 1'b0;
            sig_buf_q     <= '0;
        end else begin
            sig_buf_vld_q <= sig_buf_vld_d;
            sig_buf_q     <= sig_buf_d;
        end
    end

    assign req0_ack    = ack0;
    assign req1_ack    = ack1;
    assign sig_buf_vld = sig_buf_vld_q;
    assign sig_buf     = sig_buf_q;

endmodule

`default_nettype wire

// File: tb/tb_iob_jbi_rptr_arb.sv
// ============================================================================
// Module  : tb_iob_jbi_rptr_arb
// Brief   : Directed self-checking bench for iob_jbi_rptr_arb.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iob_jbi_rptr_arb;
    import iob_jbi_rptr_pkg::*;

    logic          clk;
    logic          rst_l;
    logic          req0_vld, req0_last;
    logic [DW-1:0] req0_data;
    logic          req0_ack;
    logic          req1_vld, req1_last;
    logic [DW-1:0] req1_data;
    logic          req1_ack;
    logic          jbi_credit_ret;
    logic          sig_buf_vld;
    logic [DW-1:0] sig_buf;
    logic [CW-1:0] credit_cnt;
    logic          credit_ovf;

    int pass_cnt;
    int total_cnt;

    iob_jbi_rptr_arb dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .req0_vld       (req0_vld),
        .req0_last      (req0_last),
        .req0_data      (req0_data),
        .req0_ack       (req0_ack),
        .req1_vld       (req1_vld),
        .req1_last      (req1_last),
        .req1_data      (req1_data),
        .req1_ack       (req1_ack),
        .jbi_credit_ret (jbi_credit_ret),
        .sig_buf_vld    (sig_buf_vld),
        .sig_buf        (sig_buf),
        .credit_cnt     (credit_cnt),
        .credit_ovf     (credit_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_l          = 1'b0;
        req0_vld       = 1'b0;
        req0_last      = 1'b0;
        req0_data      = '0;
        req1_vld       = 1'b0;
        req1_last      = 1'b0;
        req1_data      = '0;
        jbi_credit_ret = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_l = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        total_cnt++;
        if (sig_buf_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", sig_buf_vld);
        else pass_cnt++;
        total_cnt++;
        if (sig_buf !== '0) $display("FAIL reset_buf: got %h want 0", sig_buf);
        else pass_cnt++;
        total_cnt++;
        if (credit_cnt !== 3'd4) $display("FAIL reset_cnt: got %0d want 4", credit_cnt);
        else pass_cnt++;
        total_cnt++;
        if (credit_ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", credit_ovf);
        else pass_cnt++;
        total_cnt++;
        if ({req0_ack, req1_ack} !== 2'b00) $display("FAIL reset_ack: got %b want 00", {req0_ack, req1_ack});
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_single_beat();
        logic [DW-1:0] pat;
        pat = {17{8'hA5}};
        apply_reset();
        req0_vld  = 1'b1;
        req0_last = 1'b1;
        req0_data = pat;
        @(negedge clk);
        total_cnt++;
        if ({req0_ack, req1_ack} !== 2'b10) $display("FAIL single_ack: got %b want 10", {req0_ack, req1_ack});
        else pass_cnt++;
        next_cycle();
        req0_vld = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (sig_buf_vld !== 1'b1) $display("FAIL single_vld: got %b want 1", sig_buf_vld);
        else pass_cnt++;
        total_cnt++;
        if (sig_buf !== pat) $display("FAIL single_data: got %h want %h", sig_buf, pat);
        else pass_cnt++;
        total_cnt++;
        if (credit_cnt !== 3'd3) $display("FAIL single_cnt: got %0d want 3", credit_cnt);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (sig_buf_vld !== 1'b0) $display("FAIL single_vld_drop: got %b want 0", sig_buf_vld);
        else pass_cnt++;
        total_cnt++;
        if (sig_buf !== pat) $display("FAIL single_hold: got %h want %h", sig_buf, pat);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] d0, d1, exp_d;
        logic [1:0]    exp_ack;
        d0 = {34{4'h3}};
        d1 = {34{4'hC}};
        apply_reset();
        req0_vld = 1'b1; req0_last = 1'b1; req0_data = d0;
        req1_vld = 1'b1; req1_last = 1'b1; req1_data = d1;
        jbi_credit_ret = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_ack = (i % 2 == 0) ? 2'b10 : 2'b01;
            total_cnt++;
            if ({req0_ack, req1_ack} !== exp_ack)
                $display("FAIL rr_ack[%0d]: got %b want %b", i, {req0_ack, req1_ack}, exp_ack);
            else pass_cnt++;
            if (i > 0) begin
                exp_d = ((i - 1) % 2 == 0) ? d0 : d1;
                total_cnt++;
                if (sig_buf !== exp_d) $display("FAIL rr_data[%0d]: got %h want %h", i, sig_buf, exp_d);
                else pass_cnt++;
            end
            next_cycle();
        end
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        jbi_credit_ret = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (credit_cnt !== 3'd4) $display("FAIL rr_cnt: got %0d want 4", credit_cnt);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_locked_packet();
        logic [1:0] exp_ack [4];
        exp_ack[0] = 2'b01; exp_ack[1] = 2'b01; exp_ack[2] = 2'b01; exp_ack[3] = 2'b10;
        apply_reset();
        req1_vld = 1'b1; req1_last = 1'b0; req1_data = {DW{1'b1}};
        for (int i = 0; i < 4; i++) begin
            if (i >= 1) begin
                req0_vld  = 1'b1;
                req0_last = 1'b1;
                req0_data = DW'(i);
            end
            if (i == 2) req1_last = 1'b1;
            if (i == 3) req1_vld  = 1'b0;
            @(negedge clk);
            total_cnt++;
            if ({req0_ack, req1_ack} !== exp_ack[i])
                $display("FAIL lock_ack[%0d]: got %b want %b", i, {req0_ack, req1_ack}, exp_ack[i]);
            else pass_cnt++;
            next_cycle();
        end
        req0_vld = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (sig_buf !== DW'(3)) $display("FAIL lock_data: got %h want 3", sig_buf);
        else pass_cnt++;
        total_cnt++;
        if (credit_cnt !== 3'd0) $display("FAIL lock_cnt: got %0d want 0", credit_cnt);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_credit_exhaust();
        apply_reset();
        req0_vld = 1'b1; req0_last = 1'b1; req0_data = {DW{1'b0}} | 136'h5A;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total_cnt++;
            if (req0_ack !== (i < 4)) $display("FAIL exh_ack[%0d]: got %b want %b", i, req0_ack, (i < 4));
            else pass_cnt++;
            if (i == 4) begin
                total_cnt++;
                if (credit_cnt !== 3'd0) $display("FAIL exh_cnt: got %0d want 0", credit_cnt);
                else pass_cnt++;
            end
            next_cycle();
        end
        jbi_credit_ret = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (req0_ack !== 1'b0) $display("FAIL ret_same_cycle: got %b want 0", req0_ack);
        else pass_cnt++;
        next_cycle();
        jbi_credit_ret = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (credit_cnt !== 3'd1) $display("FAIL ret_cnt: got %0d want 1", credit_cnt);
        else pass_cnt++;
        total_cnt++;
        if (req0_ack !== 1'b1) $display("FAIL ret_next_cycle: got %b want 1", req0_ack);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (req0_ack !== 1'b0 || credit_cnt !== 3'd0)
            $display("FAIL ret_one_only: got ack=%b cnt=%0d want ack=0 cnt=0", req0_ack, credit_cnt);
        else pass_cnt++;
        next_cycle();
        req0_vld = 1'b0;
    endtask

    task automatic test_credit_ovf();
        apply_reset();
        jbi_credit_ret = 1'b1;
        next_cycle();
        jbi_credit_ret = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (credit_cnt !== 3'd4) $display("FAIL ovf_cnt: got %0d want 4", credit_cnt);
        else pass_cnt++;
        total_cnt++;
        if (credit_ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", credit_ovf);
        else pass_cnt++;
        repeat (3) next_cycle();
        @(negedge clk);
        total_cnt++;
        if (credit_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", credit_ovf);
        else pass_cnt++;
        rst_l = 1'b0;
        #1;
        total_cnt++;
        if (credit_ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", credit_ovf);
        else pass_cnt++;
        next_cycle();
        rst_l = 1'b1;
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        req0_vld = 1'b1; req0_last = 1'b0; req0_data = {DW{1'b1}};
        @(negedge clk);
        total_cnt++;
        if (req0_ack !== 1'b1) $display("FAIL mid_first_ack: got %b want 1", req0_ack);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (credit_cnt !== 3'd3 || sig_buf_vld !== 1'b1)
            $display("FAIL mid_pre_rst: got cnt=%0d vld=%b want cnt=3 vld=1", credit_cnt, sig_buf_vld);
        else pass_cnt++;
        rst_l = 1'b0;
        #1;
        total_cnt++;
        if (sig_buf_vld !== 1'b0 || credit_cnt !== 3'd4 || req0_ack !== 1'b0)
            $display("FAIL mid_in_rst: got vld=%b cnt=%0d ack=%b want 0/4/0", sig_buf_vld, credit_cnt, req0_ack);
        else pass_cnt++;
        next_cycle();
        req0_vld = 1'b0;
        rst_l    = 1'b1;
        req1_vld = 1'b1; req1_last = 1'b1; req1_data = {68{2'b10}};
        @(negedge clk);
        total_cnt++;
        if ({req0_ack, req1_ack} !== 2'b01) $display("FAIL mid_post_ack: got %b want 01", {req0_ack, req1_ack});
        else pass_cnt++;
        next_cycle();
        req1_vld = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (sig_buf !== {68{2'b10}} || sig_buf_vld !== 1'b1)
            $display("FAIL mid_post_data: got vld=%b data=%h want vld=1 data=%h", sig_buf_vld, sig_buf, {68{2'b10}});
        else pass_cnt++;
        next_cycle();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_single_beat();
        test_round_robin();
        test_locked_packet();
        test_credit_exhaust();
        test_credit_ovf();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
